// File: rtl/fetch_queue.sv
// Instruction buffer between I-cache fetch and decode: circular storage of
// fetch groups, in-order delivery of up to DEC_WIDTH oldest entries per cycle.
module fetch_queue #(
   parameter int ADDR        = 32,
   parameter int INST        = 32,
   parameter int FETCH_WIDTH = 2,
   parameter int DEC_WIDTH   = 2,
   parameter int DEPTH       = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic                           ic_valid,
   output logic                           ic_ready,
   input  logic [ADDR-1:0]                ic_pc,
   input  logic [FETCH_WIDTH*INST-1:0]    ic_inst,
   input  logic [FETCH_WIDTH-1:0]         ic_mask,
   input  logic [FETCH_WIDTH-1:0]         ic_br_pred,
   output logic [DEC_WIDTH-1:0]           dec_valid,
   output logic [DEC_WIDTH*INST-1:0]      dec_inst,
   output logic [DEC_WIDTH*ADDR-1:0]      dec_pc,
   output logic [DEC_WIDTH-1:0]           dec_br_pred,
   input  logic [$clog2(DEC_WIDTH+1)-1:0] dec_take,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int PW   = $clog2(DEPTH);
   localparam int PTRW = PW + 1;
   localparam int CW   = $clog2(DEPTH + 1);
   localparam int NW   = $clog2(FETCH_WIDTH + 1);

   logic [INST-1:0] mem_inst [DEPTH];
   logic [ADDR-1:0] mem_pc   [DEPTH];
   logic            mem_br   [DEPTH];

   logic [PTRW-1:0] head;
   logic [PTRW-1:0] tail;

   logic [NW-1:0]   enq_n;
   logic            enq_stop;
   logic            enq_fire;
   logic [CW-1:0]   enq_cnt;
   logic [CW-1:0]   avail;
   logic [CW-1:0]   taken;
   logic [PW-1:0]   widx [FETCH_WIDTH];
   logic [PW-1:0]   ridx;

   // Group length: leading ones of the mask, cut just after the first predicted-taken slot.
   always_comb begin
      enq_n    = '0;
      enq_stop = 1'b0;
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (!enq_stop) begin
            if (ic_mask[k]) begin
               enq_n    = enq_n + NW'(1);
               enq_stop = ic_br_pred[k];
            end else begin
               enq_stop = 1'b1;
            end
         end
      end
   end

   assign ic_ready = !reset && ((CW'(DEPTH) - count) >= CW'(FETCH_WIDTH));
   assign enq_fire = ic_valid && ic_ready;
   assign enq_cnt  = enq_fire ? CW'(enq_n) : '0;

   assign avail = (count < CW'(DEC_WIDTH)) ? count : CW'(DEC_WIDTH);
   assign taken = (CW'(dec_take) > avail) ? avail : CW'(dec_take);

   always_comb begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         widx[k] = tail[PW-1:0] + PW'(k);
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
         if (enq_fire && (NW'(k) < enq_n)) begin
            mem_inst[widx[k]] <= ic_inst[k*INST +: INST];
            mem_pc[widx[k]]   <= ic_pc + ADDR'(4 * k);
            mem_br[widx[k]]   <= ic_br_pred[k];
         end
      end
   end

   // Occupancy is tracked in its own register so full never depends on pointer equality.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTRW'(taken);
         tail  <= tail + PTRW'(enq_cnt);
         count <= count + enq_cnt - taken;
      end
   end

   // Invalid slots are driven to zero so never-written storage does not leak out.
   always_comb begin
      dec_valid   = '0;
      dec_inst    = '0;
      dec_pc      = '0;
      dec_br_pred = '0;
      ridx        = '0;
      for (int k = 0; k < DEC_WIDTH; k++) begin
         ridx         = head[PW-1:0] + PW'(k);
         dec_valid[k] = count > CW'(k);
         if (dec_valid[k]) begin
            dec_inst[k*INST +: INST] = mem_inst[ridx];
            dec_pc[k*ADDR +: ADDR]   = mem_pc[ridx];
            dec_br_pred[k]           = mem_br[ridx];
         end
      end
   end

   dec_take_overrun: assert property (@(posedge clk) disable iff (reset) CW'(dec_take) <= avail);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: stimulus pushes expected entries into a
// scoreboard, a negedge monitor pops and compares every slot decode consumes.
module tb_fetch_queue;

   localparam int ADDR = 32;
   localparam int INST = 32;

   typedef struct packed {
      logic [ADDR-1:0] pc;
      logic [INST-1:0] inst;
      logic            br;
   } ent_t;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          ic_valid;
   logic          ic_ready;
   logic [31:0]   ic_pc;
   logic [63:0]   ic_inst;
   logic [1:0]    ic_mask;
   logic [1:0]    ic_br_pred;
   logic [1:0]    dec_valid;
   logic [63:0]   dec_inst;
   logic [63:0]   dec_pc;
   logic [1:0]    dec_br_pred;
   logic [1:0]    dec_take;
   logic [3:0]    count;

   ent_t sb [$];
   int   mcount;
   int   checks;
   int   errors;

   fetch_queue #(
      .ADDR(ADDR), .INST(INST), .FETCH_WIDTH(2), .DEC_WIDTH(2), .DEPTH(8)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .ic_valid(ic_valid), .ic_ready(ic_ready), .ic_pc(ic_pc),
      .ic_inst(ic_inst), .ic_mask(ic_mask), .ic_br_pred(ic_br_pred),
      .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
      .dec_br_pred(dec_br_pred), .dec_take(dec_take), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ pc;
   endfunction

   function automatic int group_len(input logic [1:0] mask, input logic [1:0] br);
      int n;
      n = 0;
      for (int k = 0; k < 2; k++) begin
         if (!mask[k]) break;
         n++;
         if (br[k]) break;
      end
      return n;
   endfunction

   // One cycle of stimulus; expected entries are queued once the edge has taken them.
   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [1:0] mask,
                                input logic [1:0] br, input int take, input logic fl,
                                input logic rst);
      logic accept;
      int   n;
      ic_valid   = v;
      ic_pc      = pc;
      ic_inst    = {inst_of(pc + 32'd4), inst_of(pc)};
      ic_mask    = mask;
      ic_br_pred = br;
      dec_take   = 2'(take);
      flush      = fl;
      reset      = rst;
      accept = v && !rst && !fl && ((8 - mcount) >= 2);
      n      = accept ? group_len(mask, br) : 0;
      @(posedge clk);
      #1;
      if (rst || fl) begin
         sb.delete();
         mcount = 0;
      end else begin
         for (int k = 0; k < n; k++) begin
            sb.push_back('{pc: pc + 32'(4 * k), inst: inst_of(pc + 32'(4 * k)), br: br[k]});
         end
         mcount = mcount + n - take;
      end
   endtask

   task automatic idle(input int take);
      applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, take, 1'b0, 1'b0);
   endtask

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input int exp_count, input logic exp_ready,
                              input logic [1:0] exp_valid);
      checkValue({name, ".count"}, 32'(count), 32'(exp_count));
      checkValue({name, ".ic_ready"}, 32'(ic_ready), 32'(exp_ready));
      checkValue({name, ".dec_valid"}, 32'(dec_valid), 32'(exp_valid));
   endtask

   // Monitor: every slot decode consumes must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            if ((k < int'(dec_take)) && dec_valid[k]) begin
               ent_t e;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL sb_underflow: slot %0d pc %0h with nothing expected",
                           k, dec_pc[k*ADDR +: ADDR]);
               end else begin
                  e = sb.pop_front();
                  if ((dec_pc[k*ADDR +: ADDR] !== e.pc) || (dec_inst[k*INST +: INST] !== e.inst) ||
                      (dec_br_pred[k] !== e.br)) begin
                     errors++;
                     $display("[TB] FAIL deliver slot%0d: got pc %0h inst %0h br %0b expected pc %0h inst %0h br %0b",
                              k, dec_pc[k*ADDR +: ADDR], dec_inst[k*INST +: INST], dec_br_pred[k],
                              e.pc, e.inst, e.br);
                  end
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      mcount = 0;
      reset = 1'b1; flush = 1'b0; ic_valid = 1'b0; ic_pc = '0; ic_inst = '0;
      ic_mask = '0; ic_br_pred = '0; dec_take = '0;

      // Reset behaviour
      applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 0, 1'b0, 1'b1);
      applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 0, 1'b0, 1'b1);
      checkOutput("reset_hold", 0, 1'b0, 2'b00);
      idle(0);
      checkOutput("after_reset", 0, 1'b1, 2'b00);

      // First group, visible the cycle after the enqueue edge
      applyStimulus(1'b1, 32'h20, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("first_group", 2, 1'b1, 2'b11);
      checkValue("first_pc0", dec_pc[31:0], 32'h20);
      checkValue("first_pc1", dec_pc[63:32], 32'h24);
      checkValue("first_inst0", dec_inst[31:0], inst_of(32'h20));
      checkValue("first_inst1", dec_inst[63:32], inst_of(32'h24));

      applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 0, 1'b1, 1'b0);
      checkOutput("flush_empty", 0, 1'b1, 2'b00);

      // Fill to full, reject while full, then free space
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(8 * i), 2'b11, 2'b00, 0, 1'b0, 1'b0);
      end
      checkOutput("full", 8, 1'b0, 2'b11);
      applyStimulus(1'b1, 32'h200, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("full_reject", 8, 1'b0, 2'b11);
      idle(2);
      checkOutput("after_take", 6, 1'b1, 2'b11);
      applyStimulus(1'b1, 32'h120, 2'b01, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("seven", 7, 1'b0, 2'b11);
      idle(1);
      checkOutput("back_to_six", 6, 1'b1, 2'b11);
      idle(2); idle(2); idle(2);
      checkOutput("drained", 0, 1'b1, 2'b00);

      // Branch truncation and mask gaps
      applyStimulus(1'b1, 32'h1c, 2'b11, 2'b01, 0, 1'b0, 1'b0);
      checkOutput("br_trunc", 1, 1'b1, 2'b01);
      checkValue("br_trunc_pc", dec_pc[31:0], 32'h1c);
      applyStimulus(1'b1, 32'h1c0, 2'b10, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("mask_gap", 1, 1'b1, 2'b01);
      applyStimulus(1'b1, 32'h300, 2'b11, 2'b10, 0, 1'b0, 1'b0);
      checkOutput("br_last_slot", 3, 1'b1, 2'b11);
      idle(2); idle(1);
      checkOutput("br_drained", 0, 1'b1, 2'b00);

      // Streaming through several wraps of the storage
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 32'(8 * i), 2'b11, 2'b00, (mcount < 2) ? mcount : 2, 1'b0, 1'b0);
         if (i > 0) checkOutput("stream", 2, 1'b1, 2'b11);
      end
      idle(2);
      checkOutput("stream_drained", 0, 1'b1, 2'b00);

      // Flush beats simultaneous enqueue and dequeue
      applyStimulus(1'b1, 32'h400, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h408, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h410, 2'b01, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("five", 5, 1'b1, 2'b11);
      applyStimulus(1'b1, 32'h500, 2'b11, 2'b00, 2, 1'b1, 1'b0);
      checkOutput("flush_combo", 0, 1'b1, 2'b00);
      applyStimulus(1'b1, 32'h600, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      checkValue("after_flush_pc0", dec_pc[31:0], 32'h600);
      idle(2);

      // Reset in the middle of a stream
      applyStimulus(1'b1, 32'h700, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h708, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h710, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("six_before_reset", 6, 1'b1, 2'b11);
      applyStimulus(1'b1, 32'h800, 2'b11, 2'b00, 0, 1'b0, 1'b1);
      checkOutput("in_reset", 0, 1'b0, 2'b00);
      applyStimulus(1'b1, 32'h40, 2'b11, 2'b00, 0, 1'b0, 1'b0);
      checkOutput("post_reset", 2, 1'b1, 2'b11);
      checkValue("post_reset_pc0", dec_pc[31:0], 32'h40);
      idle(2);
      checkOutput("final", 0, 1'b1, 2'b00);
      checkValue("sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
